dct8_chen_stream: RTL

- 8-point 1-D forward DCT, Chen butterfly factorisation, orthonormal scaling.
- Streaming valid/ready on both sides with full backpressure.
- Parametrised input, constant, fraction and output widths; rounding and optional saturation on every output.
- Row counter flags the 8th row of each block, so two instances plus a transpose buffer form the 8x8 2-D DCT in the compression datapath.

---
 rtl/dct_pkg.sv | 29 ++
 rtl/dct_round_sat.sv | 35 +++
 rtl/dct8_chen_stream.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared helpers for the 8-point Chen DCT: cosine constants, accumulator sizing, row counter type.
package dct_pkg;

    localparam int ROWS_PER_BLOCK = 8;

    typedef logic [2:0] row_cnt_t;

    // Accumulator must hold a sum of four constant*difference products plus headroom.
    function automatic int acc_w(input int in_w, input int const_w);
        return in_w + const_w + 4;
    endfunction

    // round(0.5*cos(k*pi/16)*2^frac) using cos values pre-scaled by 2^30.
    function automatic int cos_const(input int k, input int frac);
        longint cos_q30;
        case (k)
            1:       cos_q30 = 64'sd1053110176;
            2:       cos_q30 = 64'sd992008095;
            3:       cos_q30 = 64'sd892783698;
            4:       cos_q30 = 64'sd759250125;
            5:       cos_q30 = 64'sd596538996;
            6:       cos_q30 = 64'sd410903207;
            7:       cos_q30 = 64'sd209476638;
            default: cos_q30 = 64'sd0;
        endcase
        return int'((cos_q30 * (64'sd1 <<< frac) + (64'sd1 <<< 30)) >>> 31);
    endfunction

endpackage

// File: rtl/dct_round_sat.sv
// Rounds an accumulator to integer and saturates (DCT8_SAT_EN) or wraps it to OUT_W; flags overflow.
module dct_round_sat #(
    parameter int ACC_W = 30,
    parameter int FRAC  = 8,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [OUT_W-1:0] y,
    output logic                    ovf
);

    localparam logic signed [ACC_W:0] HALF  = {{(ACC_W + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;
    localparam logic [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] rnd;

    always_comb begin
        // One extra bit so adding the rounding half can never overflow.
        sum = {acc[ACC_W-1], acc} + HALF;
        rnd = sum >>> FRAC;
        ovf = (rnd > MAX_V) || (rnd < MIN_V);
`ifdef DCT8_SAT_EN
        if (rnd > MAX_V)      y = Y_MAX;
        else if (rnd < MIN_V) y = Y_MIN;
        else                  y = rnd[OUT_W-1:0];
`else
        y = rnd[OUT_W-1:0];
`endif
    end

endmodule

// File: rtl/dct8_chen_stream.sv
// Streaming 8-point 1-D forward DCT (Chen butterflies), 3-stage pipeline with full backpressure.
// Define DCT8_SAT_EN to saturate outputs and enable the sticky sat_flag; otherwise outputs wrap.
module dct8_chen_stream
    import dct_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int CONST_W = 10,
    parameter int FRAC    = 8,
    parameter int OUT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0][IN_W-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0][OUT_W-1:0] out_data,
    output logic                  out_last,
    output logic                  sat_flag
);

    localparam int ACC_W = acc_w(IN_W, CONST_W);

    if (CONST_W < FRAC + 2) begin : g_const_w_check
        $error("dct8_chen_stream: CONST_W must be at least FRAC+2");
    end

    // Stage-1 butterfly vector and stage-2 accumulator vector element types.
    typedef logic signed [IN_W:0]    s1_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    localparam logic signed [CONST_W-1:0] K1 = CONST_W'(cos_const(1, FRAC));
    localparam logic signed [CONST_W-1:0] K2 = CONST_W'(cos_const(2, FRAC));
    localparam logic signed [CONST_W-1:0] K3 = CONST_W'(cos_const(3, FRAC));
    localparam logic signed [CONST_W-1:0] K4 = CONST_W'(cos_const(4, FRAC));
    localparam logic signed [CONST_W-1:0] K5 = CONST_W'(cos_const(5, FRAC));
    localparam logic signed [CONST_W-1:0] K6 = CONST_W'(cos_const(6, FRAC));
    localparam logic signed [CONST_W-1:0] K7 = CONST_W'(cos_const(7, FRAC));
    localparam acc_t C1 = acc_t'(K1), C2 = acc_t'(K2), C3 = acc_t'(K3), C4 = acc_t'(K4);
    localparam acc_t C5 = acc_t'(K5), C6 = acc_t'(K6), C7 = acc_t'(K7);

    logic v1, v2, v3, en;
    s1_t  s_d [4], d_d [4], s_q [4], d_q [4];
    acc_t e0, e1, e2, e3;
    acc_t dd    [4];
    acc_t acc_d [8], acc_q [8];
    logic [7:0][OUT_W-1:0] y_d;
    logic [7:0] ovf;
    row_cnt_t row_cnt;

    // Whole pipeline freezes while the output row is held; bubbles travel with it.
    assign en        = !v3 || out_ready;
    assign in_ready  = en && !clr;
    assign out_valid = v3;
    assign out_last  = v3 && (row_cnt == row_cnt_t'(ROWS_PER_BLOCK - 1));

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            s_d[k] = s1_t'($signed(in_data[k])) + s1_t'($signed(in_data[7-k]));
            d_d[k] = s1_t'($signed(in_data[k])) - s1_t'($signed(in_data[7-k]));
            dd[k]  = acc_t'(d_q[k]);
        end
        e0 = acc_t'(s_q[0]) + acc_t'(s_q[3]);
        e1 = acc_t'(s_q[1]) + acc_t'(s_q[2]);
        e2 = acc_t'(s_q[0]) - acc_t'(s_q[3]);
        e3 = acc_t'(s_q[1]) - acc_t'(s_q[2]);
        acc_d[0] = C4 * (e0 + e1);
        acc_d[4] = C4 * (e0 - e1);
        acc_d[2] = C2 * e2 + C6 * e3;
        acc_d[6] = C6 * e2 - C2 * e3;
        acc_d[1] = C1 * dd[0] + C3 * dd[1] + C5 * dd[2] + C7 * dd[3];
        acc_d[3] = C3 * dd[0] - C7 * dd[1] - C1 * dd[2] - C5 * dd[3];
        acc_d[5] = C5 * dd[0] - C1 * dd[1] + C7 * dd[2] + C3 * dd[3];
        acc_d[7] = C7 * dd[0] - C5 * dd[1] + C3 * dd[2] - C1 * dd[3];
    end

    for (genvar i = 0; i < 8; i++) begin : g_round
        dct_round_sat #(.ACC_W(ACC_W), .FRAC(FRAC), .OUT_W(OUT_W)) u_round_sat (
            .acc (acc_q[i]),
            .y   (y_d[i]),
            .ovf (ovf[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            row_cnt <= '0;
            out_data <= '0;
            // NOTE: datapath registers are reset too, so out_data reads 0 out of reset.
            for (int k = 0; k < 4; k++) begin
                s_q[k] <= '0;
                d_q[k] <= '0;
            end
            for (int k = 0; k < 8; k++) acc_q[k] <= '0;
        end else if (clr) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            row_cnt <= '0;
        end else begin
            if (en) begin
                v1 <= in_valid;
                v2 <= v1;
                v3 <= v2;
                if (in_valid) begin
                    for (int k = 0; k < 4; k++) begin
                        s_q[k] <= s_d[k];
                        d_q[k] <= d_d[k];
                    end
                end
                if (v1) begin
                    for (int k = 0; k < 8; k++) acc_q[k] <= acc_d[k];
                end
                if (v2) out_data <= y_d;
            end
            if (v3 && out_ready) row_cnt <= row_cnt + 1'b1;
        end
    end

`ifdef DCT8_SAT_EN
    logic sat_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     sat_q <= 1'b0;
        else if (clr)                sat_q <= 1'b0;
        else if (en && v2 && |ovf)   sat_q <= 1'b1;
    end
    assign sat_flag = sat_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^ovf;
    assign sat_flag   = 1'b0;
`endif

endmodule
